// File: rtl/load_read_unit_pkg.sv
// load_read_unit_pkg
//   Shared definitions for the memory-stage load path: load-type codes,
//   address map of data memory and the two timer blocks, FSM state encoding,
//   and an address-window helper.
package load_read_unit_pkg;

    localparam int LDTYPE_WIDE = 3;

    // Load-type codes carried on LdType
    localparam logic [LDTYPE_WIDE-1:0] LD_NOLOAD = 3'd0;
    localparam logic [LDTYPE_WIDE-1:0] LD_LW     = 3'd1;
    localparam logic [LDTYPE_WIDE-1:0] LD_LH     = 3'd2;
    localparam logic [LDTYPE_WIDE-1:0] LD_LHU    = 3'd3;
    localparam logic [LDTYPE_WIDE-1:0] LD_LB     = 3'd4;
    localparam logic [LDTYPE_WIDE-1:0] LD_LBU    = 3'd5;

    // Address map (inclusive bounds)
    localparam logic [31:0] MIN_DM    = 32'h0000_0000;
    localparam logic [31:0] MAX_DM    = 32'h0000_2FFF;
    localparam logic [31:0] MIN_TC0   = 32'h0000_7F00;
    localparam logic [31:0] MAX_TC0   = 32'h0000_7F0B;
    localparam logic [31:0] MIN_TC1   = 32'h0000_7F10;
    localparam logic [31:0] MAX_TC1   = 32'h0000_7F1B;
    localparam logic [31:0] TC0_COUNT = 32'h0000_7F08;
    localparam logic [31:0] TC1_COUNT = 32'h0000_7F18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic in_win(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/load_read_unit_if.sv
// load_read_unit_if
//   Read bus between the load unit (master) and the DM/timer fabric (slave).
//   Ports:
//     bus_req   master->slave  read request
//     bus_addr  master->slave  word-aligned read address
//     bus_rdata slave->master  read word
//     bus_ack   slave->master  read acknowledge
//   Handshake: the master raises bus_req with bus_addr and holds both stable
//   until it samples bus_ack=1 on a rising clk edge; bus_rdata is valid only in
//   that cycle. bus_ack is a single-cycle pulse and is ignored while bus_req=0.
//   The master may also withdraw bus_req after its timeout expires.
interface load_read_unit_if;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (output bus_req, bus_addr, input bus_rdata, bus_ack);
    modport slave  (input bus_req, bus_addr, output bus_rdata, bus_ack);
endinterface

// File: rtl/load_read_unit_ext.sv
// load_ext
//   Combinational load-data extractor: selects the byte/half/word addressed
//   by the low address bits from a bus word and sign- or zero-extends it.
//   Ports:
//     ld_type  in  load-type code
//     ad       in  byte offset within the word (little-endian lanes)
//     word     in  raw bus word
//     data     out extended result
module load_ext
    import load_read_unit_pkg::*;
(
    input  logic [LDTYPE_WIDE-1:0] ld_type,
    input  logic [1:0]             ad,
    input  logic [31:0]            word,
    output logic [31:0]            data
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half = ad[1] ? word[31:16] : word[15:0];
        case (ad)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase

        data = word;
        case (ld_type)
            LD_LH:   data = {{16{half[15]}}, half};
            LD_LHU:  data = {16'h0000, half};
            LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  data = {24'h000000, byte_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/load_read_unit.sv
// load_read_unit
//   Memory-stage load path. Checks the load address, issues a word-aligned
//   read on the DM/timer bus, waits for the acknowledge (bounded by a
//   timeout), extends the returned data and pulses ld_done. Holds the
//   pipeline stalled while the read is outstanding.
//   Ports:
//     clk        in   clock, rising edge
//     reset      in   asynchronous active-low reset
//     ld_valid   in   load request present in M
//     LdType     in   load-type code
//     Addr       in   byte address
//     Inq        in   interrupt/exception flush
//     DMOv       in   address-calculation overflow
//     bus        --   read bus (master side)
//     ld_data    out  extended load result, held until next completion
//     ld_done    out  one-cycle completion pulse
//     AdEL       out  one-cycle load address exception pulse
//     stall      out  freeze F/D/E/M
//     state_dbg  out  current FSM state
module load_read_unit
    import load_read_unit_pkg::*;
#(
    parameter int LDTYPE_W    = LDTYPE_WIDE,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_valid,
    input  logic [LDTYPE_W-1:0]   LdType,
    input  logic [31:0]           Addr,
    input  logic                  Inq,
    input  logic                  DMOv,
    load_read_unit_if.master      bus,
    output logic [31:0]           ld_data,
    output logic                  ld_done,
    output logic                  AdEL,
    output logic                  stall,
    output state_t                state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    state_t              state;
    logic                cancel_q;
    logic [1:0]          ad_q;
    logic [LDTYPE_W-1:0] type_q;
    logic [CNT_W-1:0]    cnt;

    logic is_load, is_word, is_half, is_timer, misaligned, out_of_range;
    logic err, accept, take_err, timeout, cancel_now;
    logic [31:0] ext_data;

    always_comb begin
        is_load  = ld_valid && (LdType != LDTYPE_W'(LD_NOLOAD));
        is_word  = (LdType == LDTYPE_W'(LD_LW));
        is_half  = (LdType == LDTYPE_W'(LD_LH)) || (LdType == LDTYPE_W'(LD_LHU));
        is_timer = in_win(Addr, MIN_TC0, MAX_TC0) || in_win(Addr, MIN_TC1, MAX_TC1);
        misaligned   = (is_word && (Addr[1:0] != 2'b00)) || (is_half && Addr[0]);
        out_of_range = !((Addr <= MAX_DM) || is_timer);
        // Timer registers only support full-word access; COUNT reads fall out legal.
        err      = misaligned || out_of_range || (is_timer && !is_word) || DMOv;
        // A flush outranks both a normal request and an address error.
        accept   = is_load && !Inq && !err;
        take_err = is_load && !Inq && err;
        timeout  = (cnt == CNT_W'(TIMEOUT_CYC - 1));
        // A flush arriving in the ack cycle itself still cancels the result.
        cancel_now = cancel_q || Inq;
        // Reset gating keeps stall low immediately during asynchronous reset.
        stall = reset && (((state == ST_IDLE) && accept) ||
                          ((state == ST_REQ) && !cancel_now));
    end

    load_ext u_ext (
        .ld_type (type_q),
        .ad      (ad_q),
        .word    (bus.bus_rdata),
        .data    (ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cancel_q     <= 1'b0;
            ad_q         <= 2'b00;
            type_q       <= '0;
            cnt          <= '0;
            bus.bus_req  <= 1'b0;
            bus.bus_addr <= 32'h0;
            ld_data      <= 32'h0;
            ld_done      <= 1'b0;
            AdEL         <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            AdEL    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state        <= ST_REQ;
                        bus.bus_req  <= 1'b1;
                        bus.bus_addr <= {Addr[31:2], 2'b00};
                        ad_q         <= Addr[1:0];
                        type_q       <= LdType;
                        cnt          <= '0;
                        cancel_q     <= 1'b0;
                    end else if (take_err) begin
                        state <= ST_ERR;
                        AdEL  <= 1'b1;
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 1'b1;
                    if (Inq) cancel_q <= 1'b1;
                    if (bus.bus_ack) begin
                        bus.bus_req <= 1'b0;
                        if (cancel_now) begin
                            state <= ST_IDLE;
                        end else begin
                            ld_data <= ext_data;
                            ld_done <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end else if (timeout) begin
                        bus.bus_req <= 1'b0;
                        if (cancel_now) begin
                            state <= ST_IDLE;
                        end else begin
                            AdEL  <= 1'b1;
                            state <= ST_ERR;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign state_dbg = state;

endmodule
